// File: rtl/iomem_gpio_irq_pkg.sv
// Shared definitions for the iomem GPIO peripheral: register offsets,
// default decode value, decoded-request struct and byte-lane helpers.
package iomem_gpio_irq_pkg;

    // Register select values carried in iomem_addr[4:2]
    localparam logic [2:0] GPIO_OUT     = 3'd0;
    localparam logic [2:0] GPIO_OE      = 3'd1;
    localparam logic [2:0] GPIO_IN      = 3'd2;
    localparam logic [2:0] GPIO_IRQ_EN  = 3'd3;
    localparam logic [2:0] GPIO_RISE_EN = 3'd4;
    localparam logic [2:0] GPIO_FALL_EN = 3'd5;
    localparam logic [2:0] GPIO_PENDING = 3'd6;
    localparam logic [2:0] GPIO_RSVD    = 3'd7;

    // Default iomem_addr[31:24] decode value
    localparam logic [7:0] GPIO_BASE_HI_DEFAULT = 8'h03;

    // One bus request after address decode
    typedef struct packed {
        logic        hit;    // accepted this cycle
        logic        wr;     // accepted and at least one strobe set
        logic [2:0]  sel;    // register select
        logic [31:0] wmask;  // byte-lane mask from the strobes
    } gpio_req_t;

    // Expand the four byte strobes into a 32-bit lane mask
    function automatic logic [31:0] wstrb_mask(input logic [3:0] wstrb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Merge write data into an old word, lane by lane
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] m;
        m = wstrb_mask(wstrb);
        return (old & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/iomem_gpio_irq_gpio_sync_edge.sv
// Per-pin input path: multi-flop synchroniser, one history flop and raw
// rise/fall detection. Enables and arming are applied by the parent.
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pad value through the synchroniser, then remember last value
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/iomem_gpio_irq.sv
// iomem GPIO peripheral for picosoc: output/OE registers, synchronised
// inputs, per-pin rise/fall interrupt sources with W1C pending bits and a
// registered level irq. One-cycle ready pulse per accepted access.
module iomem_gpio_irq
    import iomem_gpio_irq_pkg::*;
#(
    parameter int         NPINS        = 8,
    parameter logic [7:0] BASE_ADDR_HI = GPIO_BASE_HI_DEFAULT,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             irq
);

    // Edges are ignored until the synchronisers and history flops hold real
    // pad values, so pins already high at reset release raise nothing.
    localparam logic [2:0] ARM_CYC = 3'(SYNC_STAGES + 1);

    logic             ready_q;
    logic [31:0]      rdata_q;
    logic [NPINS-1:0] out_q, oe_q, ien_q, ren_q, fen_q, pend_q;
    logic [NPINS-1:0] pend_d;
    logic             irq_q;
    logic [2:0]       arm_cnt_q;
    logic             armed;

    logic [NPINS-1:0] sync_w, rise_w, fall_w;
    logic [NPINS-1:0] edge_set, pend_clr, wr_pins;
    logic [31:0]      rd_val;
    gpio_req_t        req;

    logic unused_addr;
    assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

    // Per-pin synchroniser and edge detector
    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .clk    (clk),
            .resetn (resetn),
            .pin_i  (gpio_in[i]),
            .sync_o (sync_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    // Address decode; a request is taken only while no ack is outstanding
    always_comb begin
        req       = '0;
        req.hit   = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR_HI);
        req.wr    = req.hit && (|iomem_wstrb);
        req.sel   = iomem_addr[4:2];
        req.wmask = wstrb_mask(iomem_wstrb);
    end

    // Read mux; narrow registers zero-extend so unused pins read 0
    always_comb begin
        rd_val = '0;
        case (req.sel)
            GPIO_OUT:     rd_val = 32'(out_q);
            GPIO_OE:      rd_val = 32'(oe_q);
            GPIO_IN:      rd_val = 32'(sync_w);
            GPIO_IRQ_EN:  rd_val = 32'(ien_q);
            GPIO_RISE_EN: rd_val = 32'(ren_q);
            GPIO_FALL_EN: rd_val = 32'(fen_q);
            GPIO_PENDING: rd_val = 32'(pend_q);
            default:      rd_val = '0;
        endcase
    end

    // New register value: old contents with strobed lanes replaced
    assign wr_pins = NPINS'(apply_wstrb(rd_val, iomem_wdata, iomem_wstrb));

    // Pending: W1C clears first, then fresh edges set, so an edge wins a tie
    always_comb begin
        armed    = (arm_cnt_q == ARM_CYC);
        edge_set = armed ? ((rise_w & ren_q) | (fall_w & fen_q)) : '0;
        pend_clr = '0;
        if (req.wr && req.sel == GPIO_PENDING)
            pend_clr = NPINS'(iomem_wdata & req.wmask);
        pend_d   = (pend_q & ~pend_clr) | edge_set;
    end

    // Bus acknowledge and read data capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= req.hit;
            if (req.hit) rdata_q <= rd_val;
        end
    end

    // Read/write configuration registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q <= '0;
            oe_q  <= '0;
            ien_q <= '0;
            ren_q <= '0;
            fen_q <= '0;
        end else if (req.wr) begin
            case (req.sel)
                GPIO_OUT:     out_q <= wr_pins;
                GPIO_OE:      oe_q  <= wr_pins;
                GPIO_IRQ_EN:  ien_q <= wr_pins;
                GPIO_RISE_EN: ren_q <= wr_pins;
                GPIO_FALL_EN: fen_q <= wr_pins;
                default:      ;
            endcase
        end
    end

    // Pending bits and the registered interrupt level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= |(pend_q & ien_q);
        end
    end

    // Arm counter: counts up after reset release and then parks
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    arm_cnt_q <= '0;
        else if (!armed) arm_cnt_q <= arm_cnt_q + 3'd1;
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = out_q;
    assign gpio_oe     = oe_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio_irq.sv
// Bench for iomem_gpio_irq: a word-level register model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_iomem_gpio_irq;

    localparam int         NP   = 8;
    localparam int         S    = 2;
    localparam logic [7:0] BASE = 8'h03;
    localparam logic [31:0] PINMASK = 32'h0000_00FF;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          iomem_valid = 1'b0;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb = 4'h0;
    logic [31:0]   iomem_addr = '0;
    logic [31:0]   iomem_wdata = '0;
    logic [31:0]   iomem_rdata;
    logic [NP-1:0] gpio_in = '1;
    logic [NP-1:0] gpio_out, gpio_oe;
    logic          irq;

    iomem_gpio_irq #(.NPINS(NP), .BASE_ADDR_HI(BASE), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Registers held as plain words indexed by offset; the pad value seen by
    // software is simply the pad sampled S clocks ago, the previous one S+1.
    logic [31:0]   m_reg [0:7];
    logic [NP-1:0] hist  [0:S];
    int            m_cnt;
    logic          m_ready, m_irq;
    logic [31:0]   m_rdata;

    logic [NP-1:0] t_sync, t_prev, t_ev;
    logic [31:0]   t_bm, t_clr;
    logic          t_hit, t_irq;
    int            t_sel;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 8; k++) m_reg[k] = '0;
            for (int k = 0; k <= S; k++) hist[k] = '0;
            m_cnt = 0; m_ready = 0; m_irq = 0; m_rdata = '0;
        end else begin
            t_sync = hist[S-1];
            t_prev = hist[S];
            t_ev   = '0;
            if (m_cnt > S)
                t_ev = (t_sync & ~t_prev & m_reg[4][NP-1:0]) | (~t_sync & t_prev & m_reg[5][NP-1:0]);
            t_irq = |(m_reg[6] & m_reg[3]);
            t_hit = iomem_valid && !m_ready && iomem_addr[31:24] == BASE;
            t_sel = int'(iomem_addr[4:2]);
            t_clr = '0;
            t_bm  = '0;
            for (int b = 0; b < 4; b++) if (iomem_wstrb[b]) t_bm[8*b +: 8] = 8'hFF;
            if (t_hit) begin
                if (t_sel == 2)      m_rdata = {24'h0, t_sync};
                else if (t_sel == 7) m_rdata = '0;
                else                 m_rdata = m_reg[t_sel];
                if (iomem_wstrb != 0) begin
                    if (t_sel == 6) t_clr = iomem_wdata & t_bm;
                    else if (t_sel != 2 && t_sel != 7)
                        m_reg[t_sel] = ((m_reg[t_sel] & ~t_bm) | (iomem_wdata & t_bm)) & PINMASK;
                end
            end
            m_reg[6] = ((m_reg[6] & ~t_clr) | {24'h0, t_ev}) & PINMASK;
            m_ready = t_hit;
            m_irq   = t_irq;
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = gpio_in;
            if (m_cnt < 1000) m_cnt++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on && resetn) begin
            check("ready", {31'h0, iomem_ready}, {31'h0, m_ready});
            check("gpio_out", {24'h0, gpio_out}, m_reg[0]);
            check("gpio_oe", {24'h0, gpio_oe}, m_reg[1]);
            check("irq", {31'h0, irq}, {31'h0, m_irq});
            if (m_ready) check("rdata", iomem_rdata, m_rdata);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] ra(input int off);
        return {BASE, 24'h0} | 32'(off * 4);
    endfunction

    // Called at a negedge; returns at the negedge where ready is seen
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r);
        int n;
        iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!iomem_ready && n < 10);
        check("ack_seen", {31'h0, iomem_ready}, 32'h1);
        r = iomem_rdata;
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        xfer(ra(off), d, s, r);
    endtask

    task automatic rd(input int off, output logic [31:0] r);
        xfer(ra(off), 32'h0, 4'h0, r);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] r;
    int          nrdy;

    initial begin
        // Reset with all pads high
        tick(3);
        check("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_out", {24'h0, gpio_out}, 32'h0);
        check("rst_oe", {24'h0, gpio_oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        resetn = 1'b1;
        chk_on = 1;
        tick(10);
        rd(6, r); check("no_spurious_pend", r, 32'h0);
        check("no_spurious_irq", {31'h0, irq}, 32'h0);
        rd(2, r); check("in_after_reset", r, 32'h0000_00FF);

        // Byte-lane write to OUT, single-cycle ready
        wr(0, 32'h1234_56A5, 4'b0001);
        check("out_lane0", {24'h0, gpio_out}, 32'h0000_00A5);
        tick(1);
        check("ready_one_cycle", {31'h0, iomem_ready}, 32'h0);
        rd(0, r); check("out_read", r, 32'h0000_00A5);
        wr(1, 32'hFFFF_FFFF, 4'hF);
        rd(1, r); check("oe_upper_zero", r, 32'h0000_00FF);
        wr(2, 32'h0, 4'hF);
        rd(2, r); check("in_ro", r, 32'h0000_00FF);

        // Rising edge on pin 0 with irq enabled
        gpio_in = 8'h00; tick(6);
        wr(4, 32'h1, 4'h1);
        wr(3, 32'h1, 4'h1);
        tick(2);
        gpio_in = 8'h01;
        tick(S + 1);
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_rise", {31'h0, irq}, 32'h1);
        rd(6, r); check("pend_rise", r, 32'h0000_0001);
        wr(6, 32'h1, 4'h1);
        tick(2);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        rd(6, r); check("pend_cleared", r, 32'h0);

        // Falling edge on pin 3 pends while masked, irq follows unmask
        gpio_in = 8'h09; tick(6);
        wr(5, 32'h08, 4'h1);
        wr(3, 32'h00, 4'h1);
        gpio_in = 8'h01; tick(6);
        rd(6, r); check("pend_fall", r, 32'h0000_0008);
        check("irq_masked", {31'h0, irq}, 32'h0);
        wr(3, 32'h08, 4'h1);
        tick(2);
        check("irq_unmasked", {31'h0, irq}, 32'h1);
        wr(6, 32'h08, 4'h1);
        tick(2);
        check("irq_fall_clr", {31'h0, irq}, 32'h0);

        // W1C racing a new rising edge on pin 2
        wr(4, 32'h05, 4'h1);
        gpio_in = 8'h05; tick(6);
        rd(6, r); check("pend_pin2", r, 32'h0000_0004);
        gpio_in = 8'h01; tick(6);
        gpio_in = 8'h05;
        tick(S);
        wr(6, 32'h04, 4'h1);
        rd(6, r); check("edge_beats_w1c", r, 32'h0000_0004);
        wr(6, 32'h04, 4'h1);
        rd(6, r); check("w1c_no_edge", r, 32'h0);

        // Foreign base address: no ack, nothing written
        iomem_valid = 1'b1; iomem_addr = 32'h0200_0000;
        iomem_wdata = 32'hFFFF_FFFF; iomem_wstrb = 4'hF;
        nrdy = 0;
        repeat (4) begin @(negedge clk); if (iomem_ready) nrdy++; end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        check("miss_no_ready", 32'(nrdy), 32'h0);
        rd(0, r); check("miss_out_kept", r, 32'h0000_00A5);
        wr(7, 32'hFFFF_FFFF, 4'hF);
        rd(7, r); check("reserved_zero", r, 32'h0);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
